// File: rtl/debug_uart_tx.sv
// debug_uart_tx
//   Memory-mapped debug console for the HF-RISCV data bus. CPU byte stores to
//   ADDR_TX are queued in a small FIFO. Each queued byte is sent on tx_o as an
//   8N1 UART frame: one start bit, eight data bits LSB first, one stop bit.
//   Every bit lasts CLK_DIV cycles. A status word can be read at ADDR_STAT.
//   Any write to ADDR_STAT clears the sticky overflow flag.
//
// Ports
//   clk_i     system clock; all state changes on the rising edge
//   rst_i     asynchronous active-high reset; aborts any frame in progress
//   addr_i    core address bus
//   data_i    core write data; a byte store arrives in [31:24]
//   data_w_i  core byte write enables; any bit set marks a write cycle
//   data_o    registered status read data; 0 when the status word is not being read
//   tx_o      UART serial output, idle high
//   busy_o    high while the FIFO holds data or a frame is being sent
//
// Status word
//   [24] busy, [25] full, [26] overflow, [30:27] low 4 bits of the FIFO count.
//   All other bits are 0.
module debug_uart_tx #(
    parameter int          CLK_DIV    = 217,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] ADDR_TX    = 32'hf00000d0,
    parameter logic [31:0] ADDR_STAT  = 32'hf00000d4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  data_w_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] D_RELOAD   = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_n;
    logic            overflow;
    logic [7:0]      sh, sh_n;
    logic [DW-1:0]   d, d_n;
    logic [2:0]      b, b_n;
    logic            tx_n;
    logic            busy_n;
    logic            wr, push_req, clr_ovf, stat_rd;
    logic            full, empty, pop, push;
    logic [CW+3:0]   count_x;
    logic [31:0]     status;
    logic            unused_bits;

    // Bus decode
    assign wr       = |data_w_i;
    assign push_req = wr && (addr_i == ADDR_TX);
    assign clr_ovf  = wr && (addr_i == ADDR_STAT);
    assign stat_rd  = !wr && (addr_i == ADDR_STAT);

    // FIFO bookkeeping. The count is one bit wider than the pointers, so a
    // full FIFO and an empty FIFO have different counts.
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    // The transmitter takes the next byte when it is idle.
    assign pop   = (state == IDLE) && !empty;
    // A push that arrives while full is still accepted when a pop frees a slot
    // in the same cycle.
    assign push  = push_req && (!full || pop);

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            if (clr_ovf)
                overflow <= 1'b0;
            else if (push_req && !push)
                overflow <= 1'b1;
        end
    end

    // FIFO storage holds only data, so it has no reset.
    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= data_i[31:24];
    end

    // Transmit FSM, next-state logic. d counts down the cycles of the current
    // bit. b counts the data bits already sent.
    always_comb begin
        state_n = state;
        tx_n    = tx_o;
        d_n     = d;
        b_n     = b;
        sh_n    = sh;
        case (state)
            IDLE: begin
                if (!empty) begin
                    sh_n    = mem[rd_ptr];
                    tx_n    = 1'b0;
                    d_n     = D_RELOAD;
                    state_n = START;
                end
            end
            START: begin
                if (d == '0) begin
                    tx_n    = sh[0];
                    b_n     = 3'd0;
                    d_n     = D_RELOAD;
                    state_n = DATA;
                end else begin
                    d_n = d - DW'(1);
                end
            end
            DATA: begin
                if (d == '0) begin
                    d_n = D_RELOAD;
                    if (b == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        sh_n = sh >> 1;
                        tx_n = sh[1];
                        b_n  = b + 3'd1;
                    end
                end else begin
                    d_n = d - DW'(1);
                end
            end
            STOP: begin
                if (d == '0)
                    state_n = IDLE;
                else
                    d_n = d - DW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // busy_o is computed from the next-cycle values. This keeps it in step
    // with the registered state and the registered count.
    assign busy_n = (count_n != '0) || (state_n != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            tx_o   <= 1'b1;
            d      <= '0;
            b      <= 3'd0;
            busy_o <= 1'b0;
        end else begin
            state  <= state_n;
            tx_o   <= tx_n;
            d      <= d_n;
            b      <= b_n;
            busy_o <= busy_n;
        end
    end

    always_ff @(posedge clk_i) begin
        sh <= sh_n;
    end

    // Status read path. The count is widened first, so taking its low
    // nibble works for any FIFO_DEPTH.
    assign count_x = (CW + 4)'(count);
    assign status  = {1'b0, count_x[3:0], overflow, full, busy_o, 24'h0};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            data_o <= '0;
        else
            data_o <= stat_rd ? status : 32'h0;
    end

    // Write-data lanes that byte stores never use, and count bits above the
    // reported nibble.
    assign unused_bits = ^{data_i[23:0], count_x[CW+3:4]};

endmodule

// File: tb/tb_debug_uart_tx.sv
`timescale 1ns/1ps
module tb_debug_uart_tx;

    localparam int          DIV   = 4;
    localparam int          DEPTH = 16;
    localparam int          FRAME = 10 * DIV;
    localparam logic [31:0] A_TX  = 32'hf00000d0;
    localparam logic [31:0] A_ST  = 32'hf00000d4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] data_o;
    logic        tx;
    logic        busy;

    debug_uart_tx #(
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(DEPTH),
        .ADDR_TX   (A_TX),
        .ADDR_STAT (A_ST)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_i  (addr),
        .data_i  (wdata),
        .data_w_i(we),
        .data_o  (data_o),
        .tx_o    (tx),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model, kept as a timeline. Edges are numbered from the last
    // reset. The transmitter takes a byte when it has one and the previous
    // frame is over. After a pop at edge p, the next pop can happen no
    // earlier than edge p + FRAME + 1.
    int          m_count;
    bit          m_ovf;
    int          m_free;
    int          m_edge;
    logic [7:0]  exp_q[$];
    logic [31:0] st_q[$];
    int          start_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_busy();
        return (m_count > 0) || (m_edge < m_free);
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'h0;
        s[24]    = model_busy();
        s[25]    = (m_count == DEPTH);
        s[26]    = m_ovf;
        s[30:27] = 4'(m_count);
        return s;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_ovf   = 1'b0;
        m_free  = 0;
        m_edge  = 0;
        exp_q.delete();
        st_q.delete();
    endtask

    // Drive one bus cycle, step the model over that edge, and check busy_o.
    task automatic cycle(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] w);
        bit pop_now, acc, preq;
        addr  = a;
        wdata = dat;
        we    = w;
        if (a == A_ST && w == 4'h0)
            st_q.push_back(model_status());
        @(posedge clk);
        preq    = (w != 4'h0) && (a == A_TX);
        pop_now = (m_count > 0) && (m_edge >= m_free);
        acc     = preq && ((m_count < DEPTH) || pop_now);
        if (pop_now) begin
            m_count--;
            m_free = m_edge + FRAME + 1;
        end
        if (w != 4'h0 && a == A_ST)
            m_ovf = 1'b0;
        if (acc) begin
            m_count++;
            exp_q.push_back(dat[31:24]);
        end else if (preq) begin
            m_ovf = 1'b1;
        end
        m_edge++;
        #1;
        check("busy", {31'h0, busy}, {31'h0, model_busy()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(32'h0, 32'h0, 4'h0);
    endtask

    task automatic store(input logic [7:0] c);
        cycle(A_TX, {c, 24'($urandom)}, 4'b1000);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_count > 0 || m_edge < m_free) && guard < 2000) begin
            idle(1);
            guard++;
        end
        check("drain_timeout", guard < 2000 ? 32'd1 : 32'd0, 32'd1);
        idle(5);
        check("pending_bytes", exp_q.size(), 32'd0);
    endtask

    // Status monitor: a status read on an edge must appear on data_o after that edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst === 1'b0 && addr == A_ST && we == 4'h0) begin
                #1;
                if (st_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL status_unexpected: got %h expected no read", data_o);
                end else begin
                    check("status", data_o, st_q.pop_front());
                end
            end
        end
    end

    // UART monitor: decode frames cycle by cycle, check bit widths, and compare
    // each decoded byte with the scoreboard.
    initial begin
        forever begin
            logic [7:0] byt;
            bit         ok;
            bit         aborted;
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                start_q.push_back(cyc);
                byt     = 8'h0;
                ok      = 1'b1;
                aborted = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i < DIV) begin
                        if (tx !== 1'b0) ok = 1'b0;
                    end else if (i >= FRAME - DIV) begin
                        if (tx !== 1'b1) ok = 1'b0;
                    end else if ((i - DIV) % DIV == 0) begin
                        byt[(i - DIV) / DIV] = tx;
                    end else if (tx !== byt[(i - DIV) / DIV]) begin
                        ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    check("framing", {31'h0, ok}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %h expected none", byt);
                    end else begin
                        check("tx_byte", {24'h0, byt}, {24'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        int r;
        rst   = 1'b1;
        addr  = 32'h0;
        wdata = 32'h0;
        we    = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'h0, tx}, 32'd1);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_data_o", data_o, 32'h0);
        #1 rst = 1'b0;

        // Single byte, with start-bit latency
        store(8'h41);
        check("latency_push_edge", {31'h0, tx}, 32'd1);
        idle(1);
        check("latency_pop_edge", {31'h0, tx}, 32'd0);
        drain();

        // Back-to-back "HI", gap between starts
        start_q.delete();
        store(8'h48);
        store(8'h49);
        drain();
        check("frame_count", start_q.size(), 32'd2);
        if (start_q.size() == 2)
            check("frame_spacing", start_q[1] - start_q[0], FRAME + 1);

        // Overflow burst while a frame is in flight
        store(8'h30);
        idle(2);
        for (int i = 0; i < 17; i++) store(8'h61 + 8'(i));
        cycle(A_ST, 32'h0, 4'h0);
        check("ovf_full_bits", {30'h0, data_o[26:25]}, 32'd3);
        cycle(A_ST, 32'h0, 4'b0001);
        cycle(A_ST, 32'h0, 4'h0);
        check("ovf_cleared", {31'h0, data_o[26]}, 32'd0);
        drain();

        // Reset during a data bit with bytes still queued
        store(8'hA5);
        store(8'h5A);
        store(8'hC3);
        idle(14);
        #2 rst = 1'b1;
        #1;
        check("midframe_rst_tx", {31'h0, tx}, 32'd1);
        check("midframe_rst_busy", {31'h0, busy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        idle(60);
        check("post_rst_tx", {31'h0, tx}, 32'd1);
        cycle(A_ST, 32'h0, 4'h0);
        check("post_rst_status", data_o, 32'h0);

        // Writes to other addresses, and a read of the data address
        cycle(32'hf00000d8, 32'h55000000, 4'b1000);
        cycle(A_TX, 32'h0, 4'h0);
        check("read_tx_addr", data_o, 32'h0);
        idle(50);
        check("no_push_tx", {31'h0, tx}, 32'd1);

        // Randomised traffic
        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 12)
                cycle(A_TX, $urandom, 4'($urandom_range(1, 15)));
            else if (r < 20)
                cycle(A_ST, $urandom, 4'h0);
            else if (r < 23)
                cycle(A_ST, $urandom, 4'($urandom_range(1, 15)));
            else if (r < 26)
                cycle((r == 23) ? 32'hf00000d8 : $urandom, $urandom, 4'($urandom_range(1, 15)));
            else if (r < 28)
                cycle(A_TX, $urandom, 4'h0);
            else
                idle(1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
